// File: rtl/tone_voice_mixer_if.sv
// Audio_Controller FIFO handshake and sample buses as seen by the tone/voice mixer.
// The mixer uses the master view; the Audio_Controller side uses the slave view.
interface tone_voice_mixer_if #(
    parameter int SAMPLE_W = 32
);
    logic                audio_in_available;
    logic                audio_out_allowed;
    logic [SAMPLE_W-1:0] left_channel_audio_in;
    logic [SAMPLE_W-1:0] right_channel_audio_in;
    logic                read_audio_in;
    logic                write_audio_out;
    logic [SAMPLE_W-1:0] left_channel_audio_out;
    logic [SAMPLE_W-1:0] right_channel_audio_out;

    modport master (
        input  audio_in_available,
        input  audio_out_allowed,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        output audio_in_available,
        output audio_out_allowed,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );
endinterface

// File: rtl/tone_voice_mixer.sv
// N-voice square-wave synthesiser, saturating mixer with optional mic/line passthrough.
// Optional decaying release envelope is enabled with `define TONE_ENVELOPE_EN.
module tone_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 32,
    parameter int DIV_W      = 19,
    parameter int AMP_W      = 16,
    parameter int DECAY_DIV  = 1024
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [NUM_VOICES-1:0]       voice_en,
    input  logic [NUM_VOICES*DIV_W-1:0] voice_half_period,
    input  logic [NUM_VOICES*AMP_W-1:0] voice_amp,
    input  logic                        mic_en,
    tone_voice_mixer_if.master          bus,
    output logic [4:0]                  active_voices
);
    localparam int ACC_W = SAMPLE_W + 5;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNAP  = 3'd1,
        S_ACCUM = 3'd2,
        S_SAT   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_fire;
    logic [IDX_W-1:0]        r_idx;
    logic signed [ACC_W-1:0] r_acc_l;
    logic signed [ACC_W-1:0] r_acc_r;
    logic [SAMPLE_W-1:0]     r_left;
    logic [SAMPLE_W-1:0]     r_right;
    logic [4:0]              r_active;
    logic [4:0]              w_active;
    logic [DIV_W-1:0]        w_hp      [NUM_VOICES];
    logic [DIV_W-1:0]        r_cnt     [NUM_VOICES];
    logic [AMP_W-1:0]        w_amp     [NUM_VOICES];
    logic [SAMPLE_W-1:0]     w_contrib [NUM_VOICES];
    logic [SAMPLE_W-1:0]     r_snap    [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_phase;
    logic [NUM_VOICES-1:0]   w_silent;

    function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] v);
        return {{5{v[SAMPLE_W-1]}}, v};
    endfunction

    function automatic logic [SAMPLE_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{6{1'b0}}, {(SAMPLE_W-1){1'b1}}};
        lo = {{6{1'b1}}, {(SAMPLE_W-1){1'b0}}};
        if (a > hi) return hi[SAMPLE_W-1:0];
        else if (a < lo) return lo[SAMPLE_W-1:0];
        else return a[SAMPLE_W-1:0];
    endfunction

    // Amplitude is zero-extended first so the full unsigned range negates correctly.
    function automatic logic [SAMPLE_W-1:0] contrib(input logic silent, input logic phase,
                                                    input logic [AMP_W-1:0] amp);
        logic [SAMPLE_W-1:0] ext;
        ext = {{(SAMPLE_W-AMP_W){1'b0}}, amp};
        if (silent) return {SAMPLE_W{1'b0}};
        else if (phase) return ext;
        else return -ext;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_hp[i] = voice_half_period[i*DIV_W +: DIV_W];
        end
    end

`ifdef TONE_ENVELOPE_EN
    localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [DEC_W-1:0] r_dcnt;
    logic [AMP_W-1:0] r_env [NUM_VOICES];
    logic             w_tick;

    assign w_tick = (r_dcnt == DEC_W'(DECAY_DIV - 1));

    // Envelope follows the amplitude while keyed, then decays on a shared prescaler tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_dcnt <= {DEC_W{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) r_env[i] <= {AMP_W{1'b0}};
        end else begin
            r_dcnt <= w_tick ? {DEC_W{1'b0}} : r_dcnt + DEC_W'(1);
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_en[i]) r_env[i] <= voice_amp[i*AMP_W +: AMP_W];
                else if (w_tick && (r_env[i] != {AMP_W{1'b0}})) r_env[i] <= r_env[i] - AMP_W'(1);
                else r_env[i] <= r_env[i];
            end
        end
    end

    always_comb begin
        w_silent = {NUM_VOICES{1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_amp[i]    = r_env[i];
            w_silent[i] = (r_env[i] == {AMP_W{1'b0}}) || (w_hp[i] == {DIV_W{1'b0}});
        end
    end
`else
    always_comb begin
        w_silent = {NUM_VOICES{1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_amp[i]    = voice_amp[i*AMP_W +: AMP_W];
            w_silent[i] = !voice_en[i] || (w_hp[i] == {DIV_W{1'b0}});
        end
    end
`endif

    always_comb begin
        w_active = 5'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_contrib[i] = contrib(w_silent[i], r_phase[i], w_amp[i]);
            w_active     = w_active + {4'd0, !w_silent[i]};
        end
    end

    // A counter left above a shortened half-period wraps without toggling, so it never locks up.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_phase  <= {NUM_VOICES{1'b0}};
            r_active <= 5'd0;
            for (int i = 0; i < NUM_VOICES; i++) r_cnt[i] <= {DIV_W{1'b0}};
        end else begin
            r_active <= w_active;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_silent[i]) begin
                    r_cnt[i]   <= {DIV_W{1'b0}};
                    r_phase[i] <= 1'b0;
                end else if (r_cnt[i] == w_hp[i] - DIV_W'(1)) begin
                    r_cnt[i]   <= {DIV_W{1'b0}};
                    r_phase[i] <= !r_phase[i];
                end else if (r_cnt[i] >= w_hp[i]) begin
                    r_cnt[i]   <= {DIV_W{1'b0}};
                end else begin
                    r_cnt[i]   <= r_cnt[i] + DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_fire = 1'b0;
        case (r_state)
            S_IDLE:  w_next = (bus.audio_in_available && bus.audio_out_allowed) ? S_SNAP : S_IDLE;
            S_SNAP:  w_next = S_ACCUM;
            S_ACCUM: w_next = (r_idx == IDX_W'(NUM_VOICES - 1)) ? S_SAT : S_ACCUM;
            S_SAT:   w_next = S_WRITE;
            S_WRITE: begin
                if (bus.audio_in_available && bus.audio_out_allowed) begin
                    w_fire = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WRITE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Mixing works only on the snapshot, so voice phase changes mid-sample cannot leak in.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= {IDX_W{1'b0}};
            r_acc_l <= {ACC_W{1'b0}};
            r_acc_r <= {ACC_W{1'b0}};
            r_left  <= {SAMPLE_W{1'b0}};
            r_right <= {SAMPLE_W{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) r_snap[i] <= {SAMPLE_W{1'b0}};
        end else begin
            r_state <= w_next;
            case (r_state)
                S_SNAP: begin
                    for (int i = 0; i < NUM_VOICES; i++) r_snap[i] <= w_contrib[i];
                    r_acc_l <= mic_en ? sext(bus.left_channel_audio_in)  : {ACC_W{1'b0}};
                    r_acc_r <= mic_en ? sext(bus.right_channel_audio_in) : {ACC_W{1'b0}};
                    r_idx   <= {IDX_W{1'b0}};
                end
                S_ACCUM: begin
                    r_acc_l <= r_acc_l + sext(r_snap[r_idx]);
                    r_acc_r <= r_acc_r + sext(r_snap[r_idx]);
                    r_idx   <= r_idx + IDX_W'(1);
                end
                S_SAT: begin
                    r_left  <= clamp(r_acc_l);
                    r_right <= clamp(r_acc_r);
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign bus.read_audio_in           = w_fire;
    assign bus.write_audio_out         = w_fire;
    assign bus.left_channel_audio_out  = r_left;
    assign bus.right_channel_audio_out = r_right;
    assign active_voices               = r_active;
endmodule
